hp_to_fixed: RTL and testbench

Multi-cycle converter from IEEE-754 half-precision to signed two's-complement fixed-point. It is the decode-side counterpart to the half-precision adder: it consumes packed hp words and produces integer or fixed-point values for downstream integer logic. The block uses a ready/valid handshake on both sides and an iterative one-bit-per-cycle shifter, so no full barrel shifter is needed. Exception codes match the adder's encoding.

---
 rtl/hp_pkg.sv | 23 ++
 rtl/hp_classify.sv | 31 +++
 rtl/hp_to_fixed.sv | 166 ++++++++++++++++
 tb/tb_hp_to_fixed.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hp_pkg.sv
// rtl/hp_pkg.sv - half-precision field constants, exception codes and converter states
package hp_pkg;

    localparam int HP_SIGN_BIT = 15;
    localparam int HP_EXP_MSB  = 14;
    localparam int HP_EXP_LSB  = 10;
    localparam int HP_MANT_W   = 10;
    localparam int HP_EXP_BIAS = 15;
    localparam int HP_EXP_MAX  = 31;

    localparam logic [1:0] EXC_OK      = 2'b00;
    localparam logic [1:0] EXC_POS_OVF = 2'b01;
    localparam logic [1:0] EXC_NEG_OVF = 2'b10;
    localparam logic [1:0] EXC_NAN     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ROUND,
        ST_DONE
    } conv_state_e;

endpackage

// File: rtl/hp_classify.sv
// rtl/hp_classify.sv - combinational decode of a half-precision word into class flags and significand
module hp_classify
    import hp_pkg::*;
(
    input  logic [15:0] hp,
    output logic        is_nan,
    output logic        is_inf,
    output logic        is_zero,
    output logic        is_denorm,
    output logic        sign,
    output logic [10:0] sig,
    output logic [4:0]  exp_eff
);

    logic [4:0]           exp_f;
    logic [HP_MANT_W-1:0] frac;

    assign exp_f = hp[HP_EXP_MSB:HP_EXP_LSB];
    assign frac  = hp[HP_MANT_W-1:0];
    assign sign  = hp[HP_SIGN_BIT];

    assign is_nan    = (exp_f == 5'(HP_EXP_MAX)) && (frac != '0);
    assign is_inf    = (exp_f == 5'(HP_EXP_MAX)) && (frac == '0);
    assign is_zero   = (exp_f == 5'd0) && (frac == '0);
    assign is_denorm = (exp_f == 5'd0) && (frac != '0);

    // Denormals share the scale of exponent 1, just without the hidden bit.
    assign sig     = {(exp_f != 5'd0), frac};
    assign exp_eff = (exp_f == 5'd0) ? 5'd1 : exp_f;

endmodule

// File: rtl/hp_to_fixed.sv
// rtl/hp_to_fixed.sv - iterative half-precision to signed fixed-point converter with ready/valid
module hp_to_fixed
    import hp_pkg::*;
#(
    parameter int OUT_W  = 32,
    parameter int FRAC_W = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      hp_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] fx_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       Exceptions
);

    // Magnitude register is at least 12 bits so narrow outputs never truncate the significand.
    localparam int MAG_W = (OUT_W < 12) ? 12 : OUT_W;
    localparam int CNT_W = 7;

    localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    conv_state_e state, state_next;

    logic             c_nan, c_inf, c_zero, c_denorm, c_sign;
    logic [10:0]      c_sig;
    logic [4:0]       c_exp;
    logic             unused_denorm;

    logic [MAG_W-1:0] mag;
    logic             guard, sticky, ovf, sign_r, dir_left;
    logic [CNT_W-1:0] cnt;

    logic signed [9:0] shamt;
    logic [9:0]        shabs;
    logic [CNT_W-1:0]  cnt_init;
    logic              is_special;

    logic [MAG_W:0]    rounded, limit;
    logic              round_up, sat;
    logic [OUT_W-1:0]  mag_out, signed_val;

    hp_classify u_classify (
        .hp        (hp_in),
        .is_nan    (c_nan),
        .is_inf    (c_inf),
        .is_zero   (c_zero),
        .is_denorm (c_denorm),
        .sign      (c_sign),
        .sig       (c_sig),
        .exp_eff   (c_exp)
    );

    assign unused_denorm = c_denorm;
    assign is_special    = c_nan | c_inf | c_zero;
    assign in_ready      = (state == ST_IDLE);
    assign out_valid     = (state == ST_DONE);

    // Signed shift that places the significand LSB at the output LSB weight.
    always_comb begin
        shamt = $signed({5'd0, c_exp}) - 10'sd25 + 10'(FRAC_W);
        shabs = shamt[9] ? -shamt : shamt;
        if (shamt[9]) begin
            cnt_init = (shabs > 10'd12) ? 7'd12 : shabs[CNT_W-1:0];
        end else begin
            cnt_init = (shabs > 10'(OUT_W)) ? 7'(OUT_W) : shabs[CNT_W-1:0];
        end
    end

    always_comb begin
        round_up   = guard & (sticky | mag[0]);
        rounded    = {1'b0, mag} + {{MAG_W{1'b0}}, round_up};
        limit      = ({{MAG_W{1'b0}}, 1'b1} << (OUT_W-1)) - {{MAG_W{1'b0}}, ~sign_r};
        sat        = ovf | (rounded > limit);
        mag_out    = rounded[OUT_W-1:0];
        signed_val = sign_r ? -mag_out : mag_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_special)          state_next = ST_DONE;
                    else if (cnt_init != '0) state_next = ST_SHIFT;
                    else                     state_next = ST_ROUND;
                end
            end
            ST_SHIFT: if (cnt == 7'd1) state_next = ST_ROUND;
            ST_ROUND: state_next = ST_DONE;
            ST_DONE:  if (out_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag        <= '0;
            guard      <= 1'b0;
            sticky     <= 1'b0;
            ovf        <= 1'b0;
            sign_r     <= 1'b0;
            dir_left   <= 1'b0;
            cnt        <= '0;
            fx_out     <= '0;
            Exceptions <= EXC_OK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_r   <= c_sign;
                        mag      <= MAG_W'(c_sig);
                        guard    <= 1'b0;
                        sticky   <= 1'b0;
                        ovf      <= 1'b0;
                        dir_left <= ~shamt[9];
                        cnt      <= cnt_init;
                        if (c_nan) begin
                            fx_out     <= '0;
                            Exceptions <= EXC_NAN;
                        end else if (c_inf) begin
                            fx_out     <= c_sign ? SAT_NEG : SAT_POS;
                            Exceptions <= c_sign ? EXC_NEG_OVF : EXC_POS_OVF;
                        end else if (c_zero) begin
                            fx_out     <= '0;
                            Exceptions <= EXC_OK;
                        end
                    end
                end
                ST_SHIFT: begin
                    cnt <= cnt - 7'd1;
                    if (dir_left) begin
                        ovf <= ovf | mag[MAG_W-1];
                        mag <= mag << 1;
                    end else begin
                        sticky <= sticky | guard;
                        guard  <= mag[0];
                        mag    <= mag >> 1;
                    end
                end
                ST_ROUND: begin
                    if (sat) begin
                        fx_out     <= sign_r ? SAT_NEG : SAT_POS;
                        Exceptions <= sign_r ? EXC_NEG_OVF : EXC_POS_OVF;
                    end else begin
                        fx_out     <= signed_val;
                        Exceptions <= EXC_OK;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hp_to_fixed.sv
// tb/tb_hp_to_fixed.sv - self-checking bench for hp_to_fixed across three output formats
module tb_hp_to_fixed;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] hp_in;
    logic [2:0]  in_valid, out_ready, in_ready, out_valid;
    logic [1:0]  exc0, exc1, exc2;
    logic [31:0] fx0;
    logic [15:0] fx1;
    logic [23:0] fx2;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    hp_to_fixed u0 (
        .clk(clk), .rst_n(rst_n), .hp_in(hp_in), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .fx_out(fx0), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .Exceptions(exc0)
    );
    hp_to_fixed #(.OUT_W(16), .FRAC_W(0)) u1 (
        .clk(clk), .rst_n(rst_n), .hp_in(hp_in), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .fx_out(fx1), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .Exceptions(exc1)
    );
    hp_to_fixed #(.OUT_W(24), .FRAC_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .hp_in(hp_in), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .fx_out(fx2), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .Exceptions(exc2)
    );

    typedef struct {
        int          k;
        logic [15:0] hp;
        longint      fx;
        logic [1:0]  exc;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic int ow_of(int k);
        return (k == 0) ? 32 : (k == 1) ? 16 : 24;
    endfunction

    function automatic int fw_of(int k);
        return (k == 2) ? 8 : 0;
    endfunction

    function automatic longint get_fx(int k);
        if (k == 0) return longint'($signed(fx0));
        if (k == 1) return longint'($signed(fx1));
        return longint'($signed(fx2));
    endfunction

    function automatic logic [1:0] get_exc(int k);
        if (k == 0) return exc0;
        if (k == 1) return exc1;
        return exc2;
    endfunction

    // Exact value sig * 2^(e-25+FRAC_W), rounded to nearest even, then saturated.
    function automatic void model(input int ow, input int fw, input logic [15:0] h,
                                  output longint fx, output logic [1:0] exc, output int lat);
        int     ex, e, k, sh;
        longint sig, q, r, half, maxpos, lim;
        logic   sg;
        sg = h[15];
        ex = int'(h[14:10]);
        sig = longint'(h[9:0]);
        maxpos = (longint'(1) << (ow - 1)) - 1;
        lat = 1;
        if (ex == 31) begin
            if (sig != 0) begin
                fx = 0; exc = 2'b11;
            end else begin
                fx = sg ? -(maxpos + 1) : maxpos; exc = sg ? 2'b10 : 2'b01;
            end
            return;
        end
        if (ex == 0 && sig == 0) begin
            fx = 0; exc = 2'b00;
            return;
        end
        if (ex != 0) sig = sig + 1024;
        e = (ex == 0) ? 1 : ex;
        k = e - 25 + fw;
        if (k >= 0) begin
            q = sig << k;
            lat = ((k > ow) ? ow : k) + 2;
        end else begin
            sh = -k;
            q = sig >> sh;
            r = sig - (q << sh);
            half = longint'(1) << (sh - 1);
            if (r > half || (r == half && q[0])) q = q + 1;
            lat = ((sh > 12) ? 12 : sh) + 2;
        end
        lim = sg ? maxpos + 1 : maxpos;
        if (q > lim) begin
            fx = sg ? -(maxpos + 1) : maxpos; exc = sg ? 2'b10 : 2'b01;
        end else begin
            fx = sg ? -q : q; exc = 2'b00;
        end
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic convert(input int k, input logic [15:0] h, output int lat);
        hp_in = h;
        in_valid[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        lat = 1;
        while (!out_valid[k] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid[k]) check($sformatf("timeout k=%0d hp=%h", k, h), 0, 1);
    endtask

    task automatic run_vec(input int k, input logic [15:0] h, input longint efx,
                           input logic [1:0] eexc, input int elat);
        int lat;
        convert(k, h, lat);
        check($sformatf("fx k=%0d hp=%h", k, h), get_fx(k), efx);
        check($sformatf("exc k=%0d hp=%h", k, h), longint'(get_exc(k)), longint'(eexc));
        if (elat > 0) check($sformatf("lat k=%0d hp=%h", k, h), longint'(lat), longint'(elat));
        @(posedge clk); #1;
        check($sformatf("ready k=%0d hp=%h", k, h), longint'(in_ready[k]), 1);
    endtask

    initial begin
        int          lat;
        longint      mfx;
        logic [1:0]  mexc;
        int          mlat;
        logic [15:0] h;

        vecs.push_back('{0, 16'h3C00, 1,           2'b00, 12});
        vecs.push_back('{0, 16'h4A21, 12,          2'b00, 9});
        vecs.push_back('{0, 16'h4100, 2,           2'b00, 11});
        vecs.push_back('{0, 16'h4300, 4,           2'b00, 11});
        vecs.push_back('{0, 16'h3800, 0,           2'b00, 13});
        vecs.push_back('{0, 16'h3E00, 2,           2'b00, 12});
        vecs.push_back('{0, 16'hF794, -31040,      2'b00, 6});
        vecs.push_back('{0, 16'h7BFF, 65504,       2'b00, 7});
        vecs.push_back('{0, 16'h8000, 0,           2'b00, 1});
        vecs.push_back('{0, 16'h0001, 0,           2'b00, 14});
        vecs.push_back('{0, 16'h7C00, 2147483647,  2'b01, 1});
        vecs.push_back('{1, 16'h7BFF, 32767,       2'b01, 7});
        vecs.push_back('{1, 16'hFC00, -32768,      2'b10, 1});
        vecs.push_back('{1, 16'h7E00, 0,           2'b11, 1});
        vecs.push_back('{2, 16'h3C00, 256,         2'b00, 4});
        vecs.push_back('{2, 16'h3800, 128,         2'b00, 5});
        vecs.push_back('{2, 16'h7BFF, 8388607,     2'b01, 15});
        vecs.push_back('{2, 16'hFBFF, -8388608,    2'b10, 15});

        rst_n     = 1'b0;
        hp_in     = '0;
        in_valid  = '0;
        out_ready = 3'b111;
        #1;
        check("reset in_ready", longint'(in_ready), 7);
        check("reset out_valid", longint'(out_valid), 0);
        check("reset fx0", get_fx(0), 0);
        check("reset exc0", longint'(exc0), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i].k, vecs[i].hp, vecs[i].fx, vecs[i].exc, vecs[i].lat);

        // Backpressure: result held, in_ready low, stray in_valid ignored.
        out_ready[0] = 1'b0;
        convert(0, 16'h4300, lat);
        hp_in = 16'h3C00;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp fx", get_fx(0), 4);
            check("bp valid", longint'(out_valid[0]), 1);
            check("bp in_ready", longint'(in_ready[0]), 0);
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("bp release valid", longint'(out_valid[0]), 0);
        check("bp release ready", longint'(in_ready[0]), 1);

        // Asynchronous reset in the middle of a shift sequence.
        hp_in = 16'h3C00;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("shift in_ready", longint'(in_ready[0]), 0);
        #2 rst_n = 1'b0;
        #1;
        check("async rst valid", longint'(out_valid[0]), 0);
        check("async rst ready", longint'(in_ready[0]), 1);
        check("async rst fx", get_fx(0), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(0, 16'h4300, 4, 2'b00, 11);

        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 100; n++) begin
                h = 16'($urandom);
                model(ow_of(k), fw_of(k), h, mfx, mexc, mlat);
                run_vec(k, h, mfx, mexc, mlat);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
